// File: rtl/alu_pkg.sv
// Shared widths, opcodes and FSM encoding for the ALU operand/result driver.
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int OP_W  = 2;

    localparam logic [OP_W-1:0] OP_ADD = 2'd0;
    localparam logic [OP_W-1:0] OP_SUB = 2'd1;
    localparam logic [OP_W-1:0] OP_CMP = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } drv_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with wrap-around pointers; DEPTH must be a power of two.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
        if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/alu_driver.sv
// Initiator for the 8-bit combinational ALU: queues commands, issues one at a time, returns results.
// Optional result chaining (previous result as operand A) is enabled by defining ALU_DRV_CHAIN_EN.
module alu_driver
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ALU_W-1:0] cmd_a,
    input  logic [ALU_W-1:0] cmd_b,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic             cmd_chain,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [ALU_W-1:0] alu_o,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ALU_W-1:0] res_data,
    output logic [OP_W-1:0]  res_op
);

    localparam int ENT_W = 2 * ALU_W + OP_W + 1;
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    logic [ENT_W-1:0] fifo_din, fifo_dout;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [ALU_W-1:0] ent_a, ent_b;
    logic [OP_W-1:0]  ent_op;
    logic             ent_chain;

    drv_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ALU_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic [ALU_W-1:0] res_data_q, res_data_d;
    logic [OP_W-1:0]  res_op_q, res_op_d;
    logic             res_valid_q, res_valid_d;
`ifdef ALU_DRV_CHAIN_EN
    logic [ALU_W-1:0] chain_q, chain_d;
`else
    logic             unused_chain;
    assign unused_chain = ent_chain;
`endif

    // Ready ignores a same-cycle pop so a full FIFO never takes a push.
    assign cmd_ready = ~fifo_full & ~rst;
    assign fifo_din  = {cmd_a, cmd_b, cmd_op, cmd_chain};
    assign {ent_a, ent_b, ent_op, ent_chain} = fifo_dout;

    alu_cmd_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid & cmd_ready),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_valid_d = res_valid_q;
        fifo_pop    = 1'b0;
`ifdef ALU_DRV_CHAIN_EN
        chain_d     = chain_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    alu_a_d  = ent_a;
`ifdef ALU_DRV_CHAIN_EN
                    if (ent_chain) alu_a_d = chain_q;
`endif
                    alu_b_d  = ent_b;
                    alu_op_d = ent_op;
                    cnt_d    = CNT_W'(ALU_LAT - 1);
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    res_data_d  = alu_o;
                    res_op_d    = alu_op_q;
                    res_valid_d = 1'b1;
`ifdef ALU_DRV_CHAIN_EN
                    chain_d     = alu_o;
`endif
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_valid_q <= 1'b0;
`ifdef ALU_DRV_CHAIN_EN
            chain_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_valid_q <= res_valid_d;
`ifdef ALU_DRV_CHAIN_EN
            chain_q     <= chain_d;
`endif
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver (DEPTH=4, ALU_LAT=1) with a behavioural ALU model.
module tb_alu_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [1:0] cmd_op = '0;
    logic       cmd_chain = 1'b0;
    logic [7:0] alu_a, alu_b, alu_o;
    logic [1:0] alu_op;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic [1:0] res_op;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // ALU model: add/sub mod 256; compare gives FF (a<b), 00 (a==b), 01 (a>b).
    always_comb begin
        case (alu_op)
            2'd0:    alu_o = alu_a + alu_b;
            2'd1:    alu_o = alu_a - alu_b;
            default: alu_o = (alu_a < alu_b) ? 8'hFF : ((alu_a == alu_b) ? 8'h00 : 8'h01);
        endcase
    end

    alu_driver #(.DEPTH(4), .ALU_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .cmd_chain (cmd_chain),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_o     (alu_o),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input logic ch);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = ch; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL push_timeout a=%0d b=%0d: cmd_ready stayed 0, required 1", a, b);
        end else begin
            tick();
        end
        cmd_valid = 1'b0; cmd_chain = 1'b0;
    endtask

    task automatic wait_result(output logic [7:0] d, output logic [1:0] op, output bit ok);
        int n = 0;
        while (!res_valid && n < 50) begin tick(); n++; end
        ok = (res_valid === 1'b1);
        d  = res_data;
        op = res_op;
        if (ok) begin
            res_ready = 1'b1; tick(); res_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_a = 8'hAA; cmd_b = 8'h55; cmd_op = 2'd1; res_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (cmd_ready !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: cmd_ready=%b res_valid=%b, required 0 0", cmd_ready, res_valid);
        end
        checks++;
        if ({alu_a, alu_b, alu_op, res_data, res_op} !== 28'd0) begin
            failures++;
            $display("FAIL reset_outs: alu_a=%0d alu_b=%0d alu_op=%0d res_data=%0d res_op=%0d, required all 0",
                     alu_a, alu_b, alu_op, res_data, res_op);
        end
        cmd_valid = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        repeat (4) tick();
        checks++;
        if (res_valid !== 1'b0 || alu_a !== 8'd0) begin
            failures++;
            $display("FAIL reset_no_push: res_valid=%b alu_a=%0d, required 0 0", res_valid, alu_a);
        end
    endtask

    task automatic test_single_add();
        cmd_a = 8'd200; cmd_b = 8'd100; cmd_op = 2'd0; cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_cycle1_valid: res_valid=%b, required 0", res_valid);
        end
        tick();
        checks++;
        if (alu_a !== 8'd200 || alu_b !== 8'd100 || alu_op !== 2'd0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_cycle2_issue: alu_a=%0d alu_b=%0d alu_op=%0d res_valid=%b, required 200 100 0 0",
                     alu_a, alu_b, alu_op, res_valid);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'd44 || res_op !== 2'd0) begin
            failures++;
            $display("FAIL add_cycle3_result: res_valid=%b res_data=%0d res_op=%0d, required 1 44 0",
                     res_valid, res_data, res_op);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (res_valid !== 1'b0 || alu_a !== 8'd200 || alu_b !== 8'd100) begin
            failures++;
            $display("FAIL add_idle_hold: res_valid=%b alu_a=%0d alu_b=%0d, required 0 200 100",
                     res_valid, alu_a, alu_b);
        end
    endtask

    task automatic test_sub_cmp();
        logic [7:0] va [4] = '{8'd5,   8'd7,  8'd3,  8'd2};
        logic [7:0] vb [4] = '{8'd10,  8'd3,  8'd3,  8'd9};
        logic [1:0] vo [4] = '{2'd1,   2'd2,  2'd3,  2'd2};
        logic [7:0] ve [4] = '{8'd251, 8'h01, 8'h00, 8'hFF};
        logic [7:0] d;
        logic [1:0] op;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            push(va[i], vb[i], vo[i], 1'b0);
            wait_result(d, op, ok);
            checks++;
            if (!ok || d !== ve[i] || op !== vo[i]) begin
                failures++;
                $display("FAIL sub_cmp[%0d]: valid=%b data=%0d op=%0d, required 1 %0d %0d",
                         i, ok, d, op, ve[i], vo[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] va [6] = '{8'd10, 8'd200, 8'd50,  8'd255, 8'd4, 8'd9};
        logic [7:0] vb [6] = '{8'd20, 8'd100, 8'd60,  8'd1,   8'd4, 8'd1};
        logic [1:0] vo [6] = '{2'd0,  2'd1,   2'd1,   2'd0,   2'd2, 2'd2};
        logic [7:0] ve [6] = '{8'd30, 8'd100, 8'd246, 8'd0,   8'd0, 8'd1};
        int idx = 0;
        int acc = -1;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(va[i], vb[i], vo[i], 1'b0);
        cmd_a = va[5]; cmd_b = vb[5]; cmd_op = vo[5]; cmd_valid = 1'b1;
        repeat (3) tick();
        checks++;
        if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 8'd30) begin
            failures++;
            $display("FAIL bp_full: cmd_ready=%b res_valid=%b res_data=%0d, required 0 1 30",
                     cmd_ready, res_valid, res_data);
        end
        res_ready = 1'b1;
        for (int it = 0; it < 80 && idx < 6; it++) begin
            if (cmd_valid && cmd_ready) acc = it;
            if (res_valid) begin
                checks++;
                if (res_data !== ve[idx] || res_op !== vo[idx]) begin
                    failures++;
                    $display("FAIL bp_order[%0d]: data=%0d op=%0d, required %0d %0d",
                             idx, res_data, res_op, ve[idx], vo[idx]);
                end
                idx++;
            end
            tick();
            if (acc == it) cmd_valid = 1'b0;
        end
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        checks++;
        if (idx != 6) begin
            failures++;
            $display("FAIL bp_count: results=%0d, required 6", idx);
        end
        checks++;
        if (acc != 2) begin
            failures++;
            $display("FAIL bp_accept_cycle: 6th accepted at release+%0d, required release+2", acc);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic [1:0] op;
        bit ok;
        bit seen = 1'b0;
        res_ready = 1'b0;
        push(8'd1, 8'd2, 2'd0, 1'b0);
        push(8'd3, 8'd4, 2'd0, 1'b0);
        push(8'd5, 8'd6, 2'd0, 1'b0);
        push(8'd7, 8'd9, 2'd1, 1'b0);
        push(8'd11, 8'd12, 2'd0, 1'b0);
        wait_result(d, op, ok);
        checks++;
        if (!ok || d !== 8'd3) begin
            failures++;
            $display("FAIL mid_first: valid=%b data=%0d, required 1 3", ok, d);
        end
        tick();
        checks++;
        if (alu_a !== 8'd3 || alu_b !== 8'd4 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_settle: alu_a=%0d alu_b=%0d res_valid=%b, required 3 4 0", alu_a, alu_b, res_valid);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b0 || alu_a !== 8'd0 || res_valid !== 1'b0 || res_data !== 8'd0) begin
            failures++;
            $display("FAIL mid_rst: cmd_ready=%b alu_a=%0d res_valid=%b res_data=%0d, required 0 0 0 0",
                     cmd_ready, alu_a, res_valid, res_data);
        end
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (res_valid) seen = 1'b1;
            tick();
        end
        res_ready = 1'b0;
        checks++;
        if (seen || alu_a !== 8'd0) begin
            failures++;
            $display("FAIL mid_flushed: res_seen=%b alu_a=%0d, required 0 0", seen, alu_a);
        end
        push(8'd7, 8'd8, 2'd0, 1'b0);
        wait_result(d, op, ok);
        checks++;
        if (!ok || d !== 8'd15 || op !== 2'd0) begin
            failures++;
            $display("FAIL mid_after: valid=%b data=%0d op=%0d, required 1 15 0", ok, d, op);
        end
    endtask

    task automatic test_chain();
        logic [7:0] d1, d2, exp2;
        logic [1:0] op1, op2;
        bit ok1, ok2;
`ifdef ALU_DRV_CHAIN_EN
        exp2 = 8'd25;
`else
        exp2 = 8'd94;
`endif
        push(8'd10, 8'd20, 2'd0, 1'b0);
        push(8'd99, 8'd5, 2'd1, 1'b1);
        wait_result(d1, op1, ok1);
        wait_result(d2, op2, ok2);
        checks++;
        if (!ok1 || d1 !== 8'd30 || op1 !== 2'd0) begin
            failures++;
            $display("FAIL chain_first: valid=%b data=%0d op=%0d, required 1 30 0", ok1, d1, op1);
        end
        checks++;
        if (!ok2 || d2 !== exp2 || op2 !== 2'd1) begin
            failures++;
            $display("FAIL chain_second: valid=%b data=%0d op=%0d, required 1 %0d 1", ok2, d2, op2, exp2);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub_cmp();
        test_backpressure();
        test_reset_mid();
        test_chain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
- Initiator side of the 8-bit ALU operand/result interface.
- Accepts operand commands (A, B, Op) through a valid/ready input handshake and buffers them in a small FIFO.
- Issues one command at a time to the combinational ALU. It holds the operands stable for ALU_LAT cycles, then samples the ALU output.
- Returns each result through a valid/ready output handshake.
- Sits between the control/sequencing logic and the ALU instance.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, minimum 2.
- ALU_LAT, 1: cycles operands are held before the ALU result is sampled; minimum 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_op  in  2  opcode: 0 add, 1 sub, 2/3 compare.
- cmd_chain  in  1  use the previous result as A; only meaningful with ALU_DRV_CHAIN_EN.
- alu_a  out  8  drives ALU input A.
- alu_b  out  8  drives ALU input B.
- alu_op  out  2  drives ALU Op.
- alu_o  in  8  ALU output O.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  captured ALU result.
- res_op  out  2  opcode that produced res_data.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset rst is synchronous and active-high.
  - While rst=1: FIFO flushed, FSM to IDLE, cmd_ready=0, res_valid=0.
  - Also while rst=1: alu_a, alu_b, alu_op, res_data and res_op = 0. Chain register = 0.
  - cmd_ready rises the first cycle after rst deasserts.
  - Reset mid-operation discards the in-flight command, the captured result and all queued commands.
- Input handshake:
  - A command is accepted on an edge where cmd_valid and cmd_ready are both 1.
  - cmd_ready = FIFO not full. It does not depend on a same-cycle pop, so a full FIFO refuses a push even while popping.
- FIFO:
  - DEPTH entries, each {a, b, op, chain}, with wrap-around pointers and a count of width clog2(DEPTH)+1.
  - No overflow or underflow under any input sequence.
- FSM IDLE:
  - If the FIFO is non-empty: pop, register the entry onto alu_a/alu_b/alu_op, load the settle counter with ALU_LAT-1, go to SETTLE.
  - If the FIFO is empty: stay in IDLE.
- FSM SETTLE:
  - alu_* are held stable.
  - When the counter reaches 0: capture alu_o into res_data and alu_op into res_op, go to HOLD. Otherwise decrement.
- FSM HOLD:
  - res_valid=1; res_data and res_op are stable.
  - When res_ready=1: drop res_valid and go to IDLE.
  - res_valid=1 with res_ready=0 holds indefinitely. The FIFO keeps accepting commands meanwhile.
- Latency:
  - Command pushed into an idle, empty block at edge 0: alu_* valid from cycle 2, result captured at the end of cycle 1+ALU_LAT, res_valid=1 from cycle 2+ALU_LAT.
  - With ALU_LAT=1: res_valid in cycle 3.
  - Best-case throughput: one result per ALU_LAT+2 cycles.
- Hold behaviour: alu_a, alu_b and alu_op keep their last issued values while the FSM is idle, so the ALU inputs do not toggle.
- Arithmetic: none is performed in the block; res_data is an exact copy of alu_o. Add and sub wrap modulo 256 inside the ALU.

Optional Feature:
ALU_DRV_CHAIN_EN:
- Defined:
  - Each captured result is also stored in an 8-bit chain register.
  - On pop, an entry with chain=1 drives alu_a from the chain register instead of its stored a.
  - Chain register = 0 after reset.
- Undefined: cmd_chain is ignored (port retained, unused); no chain register exists.

Decomposition:
- Package alu_pkg holds:
  - ALU_W = 8 and OP_W = 2.
  - Opcode constants OP_ADD = 0, OP_SUB = 1, OP_CMP = 2.
  - FSM state encoding IDLE/SETTLE/HOLD.
- Sub-module alu_cmd_fifo: synchronous FIFO, parameterized on DEPTH and entry width, with push/pop/full/empty. The top level holds the FSM, the settle counter and the result registers.

Test Plan:
- Reset: rst=1 for 3 cycles with cmd_valid=1 -> cmd_ready=0, res_valid=0, all outputs 0; cmd_ready=1 the cycle after release.
- Single add, ALU_LAT=1 (bench ALU model: add/sub mod 256): push a=200, b=100, op=0 at edge 0 -> res_valid in cycle 3, res_data=44, res_op=0.
- Subtract with wrap: a=5, b=10, op=1 -> res_data=251. Compare op=2 -> res_data equals model comparator output.
- Backpressure/full (DEPTH=4): hold res_ready=0 and push 6 commands -> first issued, 4 queued, cmd_ready=0 with the 6th refused. Release res_ready -> 5 results in order; the 6th is accepted once space exists.
- Reset mid-op: assert rst during SETTLE with 3 queued -> no res_valid afterwards; FIFO empty; next command processed normally.
- ALU_DRV_CHAIN_EN: push (a=10, b=20, op=0), then (a=99, b=5, op=1, chain=1) -> results 30, then 25. Without the macro -> 30, then 94.
